div_arbiter: RTL

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/div_arbiter.sv
// Two-requester round-robin front end for one shared divider.
// Latency: valid rises k+3 cycles after the sampled request (k = divider latency); a zero divisor gives 2.
// Backpressure: none. Requests are latched as pending, and a repeat request overwrites its operands.
module div_arbiter #(
  parameter int NUM_WIDTH = 20,
  parameter int DEN_WIDTH = 14,
  parameter int QUO_WIDTH = 10,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0,
  input  logic [NUM_WIDTH-1:0] num0,
  input  logic [DEN_WIDTH-1:0] den0,
  input  logic                 req1,
  input  logic [NUM_WIDTH-1:0] num1,
  input  logic [DEN_WIDTH-1:0] den1,
  output logic                 div_start,
  output logic [NUM_WIDTH-1:0] div_num,
  output logic [DEN_WIDTH-1:0] div_den,
  input  logic                 div_done,
  input  logic [QUO_WIDTH-1:0] div_quo,
  output logic                 valid0,
  output logic                 valid1,
  output logic [QUO_WIDTH-1:0] result,
  output logic                 err,
  output logic                 busy
);

  localparam int WAIT_WIDTH = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_WIDTH-1:0] WAIT_LAST = WAIT_WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_pend0;
  logic                  r_pend1;
  logic                  r_last_grant;
  logic                  r_grant;
  logic [NUM_WIDTH-1:0]  r_num0;
  logic [NUM_WIDTH-1:0]  r_num1;
  logic [DEN_WIDTH-1:0]  r_den0;
  logic [DEN_WIDTH-1:0]  r_den1;
  logic [WAIT_WIDTH-1:0] r_wait;

  logic                  w_grant_vld;
  logic                  w_grant_sel;
  logic                  w_den_zero;
  logic                  w_done_ok;
  logic                  w_timeout;
  logic [WAIT_WIDTH-1:0] w_wait_inc;
  logic [NUM_WIDTH-1:0]  w_sel_num;
  logic [DEN_WIDTH-1:0]  w_sel_den;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, grant choice and BUSY exit conditions.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_vld = 1'b0;
    w_grant_sel = 1'b0;
    w_done_ok   = 1'b0;
    w_timeout   = 1'b0;
    w_wait_inc  = r_wait + 1'b1;
    w_sel_num   = r_num0;
    w_sel_den   = r_den0;
    w_den_zero  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_pend0 || r_pend1) begin
          w_grant_vld = 1'b1;
          // With both pending, the requester not served last wins.
          w_grant_sel = (r_pend0 && r_pend1) ? ~r_last_grant : r_pend1;
          w_sel_num   = w_grant_sel ? r_num1 : r_num0;
          w_sel_den   = w_grant_sel ? r_den1 : r_den0;
          w_den_zero  = (w_sel_den == '0);
          w_state_nxt = w_den_zero ? ST_RESP : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (div_done) begin
          w_done_ok   = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (w_wait_inc == WAIT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Pending flags and operand capture; a request arriving in RESP keeps its flag set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pend0 <= 1'b0;
      r_pend1 <= 1'b0;
      r_num0  <= '0;
      r_num1  <= '0;
      r_den0  <= '0;
      r_den1  <= '0;
    end else begin
      if (req0) begin
        r_pend0 <= 1'b1;
        r_num0  <= num0;
        r_den0  <= den0;
      end else if (r_state == ST_RESP && !r_grant) begin
        r_pend0 <= 1'b0;
      end
      if (req1) begin
        r_pend1 <= 1'b1;
        r_num1  <= num1;
        r_den1  <= den1;
      end else if (r_state == ST_RESP && r_grant) begin
        r_pend1 <= 1'b0;
      end
    end
  end

  // Divider launch: operands are registered and start pulses once per nonzero-divisor grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_start <= 1'b0;
      div_num   <= '0;
      div_den   <= '0;
      r_grant   <= 1'b0;
    end else begin
      div_start <= 1'b0;
      if (w_grant_vld) begin
        r_grant <= w_grant_sel;
        if (!w_den_zero) begin
          div_start <= 1'b1;
          div_num   <= w_sel_num;
          div_den   <= w_sel_den;
        end
      end
    end
  end

  // BUSY wait counter, cleared at each grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                   r_wait <= '0;
    else if (w_grant_vld)         r_wait <= '0;
    else if (r_state == ST_BUSY)  r_wait <= w_wait_inc;
  end

  // Result/err: quotient on done, saturated on zero divisor or timeout; held otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result <= '0;
      err    <= 1'b0;
    end else if (w_done_ok) begin
      result <= div_quo;
      err    <= 1'b0;
    end else if (w_timeout || (w_grant_vld && w_den_zero)) begin
      result <= '1;
      err    <= 1'b1;
    end
  end

  // Response pulse to the granted requester and round-robin bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid0       <= 1'b0;
      valid1       <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      valid0 <= (r_state == ST_RESP) && !r_grant;
      valid1 <= (r_state == ST_RESP) &&  r_grant;
      if (r_state == ST_RESP) r_last_grant <= r_grant;
    end
  end

  assign busy = (r_state != ST_IDLE);

endmodule
